// File: rtl/vram_stream_reader.sv
// Streams a framed VRAM region (magic, 11-bit length, payload, XOR checksum) on valid/ready.
// A 2-entry skid buffer absorbs the 1-cycle RAM read latency so the consumer may stall freely.
module vram_stream_reader #(
    parameter int unsigned AW        = 11,
    parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] vram_size,
    output logic [AW-1:0] vram_read_address,
    output logic          vram_read_clock,
    input  logic [7:0]    vram_output,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        HDR2 = 3'd3,
        DATA = 3'd4,
        SUM  = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [AW-1:0] size_q, size_d;
    logic [AW-1:0] pay_cnt, pay_cnt_d;
    logic [7:0]    csum, csum_d;
    logic [7:0]    out_data_d;
    logic          out_valid_d, busy_d, done_d;

    logic          rd_more, rd_pend;
    logic [7:0]    skid [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;

    logic          pop_c, flush_c, frame_start_c, issue_c, have_c, accept_c, last_c;
    logic [1:0]    occ_c;
    logic [7:0]    head_c, csum_nx_c;
    logic [AW-1:0] last_addr_c;

    assign vram_read_clock = clk;
    assign accept_c        = out_valid & out_ready;
    assign have_c          = (count != 2'd0);
    assign head_c          = skid[rd_ptr];
    assign last_addr_c     = size_q - AW'(1);
    assign last_c          = (pay_cnt == last_addr_c);
    assign csum_nx_c       = csum ^ out_data;

    // Occupancy after this edge's pop, counting the read landing now; gate new reads on it.
    assign occ_c   = count + 2'(rd_pend) - 2'(pop_c);
    assign issue_c = rd_more & (occ_c < 2'd2);

    // Next-state and output-register logic
    always_comb begin
        state_d       = state;
        size_d        = size_q;
        pay_cnt_d     = pay_cnt;
        csum_d        = csum;
        out_data_d    = out_data;
        out_valid_d   = out_valid;
        busy_d        = busy;
        done_d        = 1'b0;
        pop_c         = 1'b0;
        flush_c       = 1'b0;
        frame_start_c = 1'b0;

        if (abort && (state != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            flush_c     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state_d       = HDR0;
                        size_d        = vram_size;
                        pay_cnt_d     = '0;
                        csum_d        = 8'h00;
                        busy_d        = 1'b1;
                        out_valid_d   = 1'b1;
                        out_data_d    = HDR_MAGIC;
                        frame_start_c = 1'b1;
                    end
                end
                HDR0: begin
                    if (accept_c) begin
                        state_d    = HDR1;
                        out_data_d = 8'(size_q >> 8);
                    end
                end
                HDR1: begin
                    if (accept_c) begin
                        state_d    = HDR2;
                        out_data_d = 8'(size_q);
                    end
                end
                HDR2: begin
                    if (accept_c) begin
                        if (size_q == '0) begin
                            state_d    = SUM;
                            out_data_d = csum;
                        end else begin
                            state_d     = DATA;
                            pop_c       = have_c;
                            out_valid_d = have_c;
                            if (have_c) out_data_d = head_c;
                        end
                    end
                end
                DATA: begin
                    if (accept_c) begin
                        csum_d = csum_nx_c;
                        if (last_c) begin
                            state_d    = SUM;
                            out_data_d = csum_nx_c;
                        end else begin
                            pay_cnt_d   = pay_cnt + AW'(1);
                            pop_c       = have_c;
                            out_valid_d = have_c;
                            if (have_c) out_data_d = head_c;
                        end
                    end else if (!out_valid && have_c) begin
                        pop_c       = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = head_c;
                    end
                end
                SUM: begin
                    if (accept_c) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            size_q    <= '0;
            pay_cnt   <= '0;
            csum      <= 8'h00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            size_q    <= size_d;
            pay_cnt   <= pay_cnt_d;
            csum      <= csum_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Read address generation and skid buffer; the RAM samples the address each edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vram_read_address <= '0;
            rd_more           <= 1'b0;
            rd_pend           <= 1'b0;
            wr_ptr            <= 1'b0;
            rd_ptr            <= 1'b0;
            count             <= 2'd0;
            skid[0]           <= 8'h00;
            skid[1]           <= 8'h00;
        end else if (flush_c || frame_start_c) begin
            vram_read_address <= '0;
            rd_more           <= frame_start_c && (vram_size != '0);
            rd_pend           <= 1'b0;
            wr_ptr            <= 1'b0;
            rd_ptr            <= 1'b0;
            count             <= 2'd0;
        end else begin
            rd_pend <= issue_c;
            if (issue_c) begin
                if (vram_read_address == last_addr_c) rd_more <= 1'b0;
                else vram_read_address <= vram_read_address + AW'(1);
            end
            if (rd_pend) begin
                skid[wr_ptr] <= vram_output;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_c) rd_ptr <= ~rd_ptr;
            count <= count + 2'(rd_pend) - 2'(pop_c);
        end
    end

endmodule

// File: tb/tb_vram_stream_reader.sv
// Directed/randomized bench for vram_stream_reader: frames are predicted from the memory image
// as header + payload + XOR and compared byte-by-byte at each accepted handshake.
module tb_vram_stream_reader;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset, start, abort, out_ready;
    logic [AW-1:0] vram_size, vram_read_address;
    logic          vram_read_clock;
    logic [7:0]    vram_output, out_data;
    logic          out_valid, busy, done;
    logic [7:0]    mem [2048];
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM: address sampled at the edge, data visible after it.
    always @(posedge clk) vram_output <= mem[vram_read_address];

    vram_stream_reader #(.AW(AW), .HDR_MAGIC(8'hA5)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .vram_size         (vram_size),
        .vram_read_address (vram_read_address),
        .vram_read_clock   (vram_read_clock),
        .vram_output       (vram_output),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .busy              (busy),
        .done              (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_frame(input int n, input int rdy_pct, input bit exact, input bit disturb);
        logic [7:0] expq [$];
        logic [7:0] x;
        logic [7:0] pd;
        logic       pv, pr;
        int         idx, cyc;
        expq.delete();
        x = 8'h00;
        expq.push_back(8'hA5);
        expq.push_back(8'(n >> 8));
        expq.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            expq.push_back(mem[i]);
            x = x ^ mem[i];
        end
        expq.push_back(x);

        @(negedge clk);
        vram_size = AW'(n);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("magic_first", 32'(out_data), 32'hA5);
        idx = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00;
        while (idx < expq.size() && cyc < 20 * (n + 4) + 100) begin
            if (pv && !pr) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'(out_data), 32'(pd));
            end
            chk("no_done_mid", 32'(done), 32'd0);
            out_ready = ($urandom_range(99) < 32'(rdy_pct));
            if (disturb) begin
                start     = (cyc == 6);
                vram_size = AW'($urandom);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("byte%0d_n%0d", idx, n), 32'(out_data), 32'(expq[idx]));
                idx++;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("frame_complete", 32'(idx), 32'(expq.size()));
        if (exact) chk("frame_cycles", 32'(cyc), 32'(n + 4));
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int idx;
        int cyc;
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; vram_size = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(vram_read_address), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("read_clock_hi", 32'(vram_read_clock), 32'd1);
        @(negedge clk);
        chk("read_clock_lo", 32'(vram_read_clock), 32'd0);

        // Basic 4-byte frame, full throughput
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        run_frame(4, 100, 1'b1, 1'b0);
        // Empty region
        fill_random();
        run_frame(0, 100, 1'b1, 1'b0);
        // Maximum region under random backpressure
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        run_frame(2047, 50, 1'b0, 1'b0);
        // Random sizes and backpressure levels
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_frame(int'($urandom_range(40, 1)), int'($urandom_range(100, 30)), 1'b0, 1'b0);
        end
        fill_random();
        run_frame(33, 100, 1'b1, 1'b0);
        // Mid-frame start pulse and size changes
        fill_random();
        run_frame(12, 70, 1'b0, 1'b1);

        // start together with abort in IDLE
        @(negedge clk);
        vram_size = AW'(5); start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("start_abort_busy2", 32'(busy), 32'd0);

        // Abort while the third payload byte is pending
        fill_random();
        @(negedge clk);
        vram_size = AW'(10); start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        idx = 0; cyc = 0;
        while (idx < 5 && cyc < 50) begin
            if (out_valid && out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        chk("abort_reached", 32'(idx), 32'd5);
        chk("abort_pending_byte", 32'(out_data), 32'(mem[2]));
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_stay_idle", 32'(out_valid), 32'd0);
        end
        fill_random();
        run_frame(9, 80, 1'b0, 1'b0);

        // Asynchronous reset during DATA with the consumer stalled
        fill_random();
        @(negedge clk);
        vram_size = AW'(20); start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        idx = 0; cyc = 0;
        while (idx < 6 && cyc < 50) begin
            if (out_valid && out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_data", 32'(out_data), 32'h00);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        chk("areset_addr", 32'(vram_read_address), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        fill_random();
        run_frame(20, 60, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
